// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO bank.
//   - CPU bus mem_mode encodings
//   - per-port register offsets inside an 8-byte window
//   - window stride between consecutive ports
package gpio_pkg;

  localparam logic [1:0] MODE_RD   = 2'b00;
  localparam logic [1:0] MODE_PC   = 2'b01;
  localparam logic [1:0] MODE_WRT  = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  localparam logic [2:0] OFS_OUT  = 3'd0;
  localparam logic [2:0] OFS_DIR  = 3'd1;
  localparam logic [2:0] OFS_IN   = 3'd2;
  localparam logic [2:0] OFS_IE   = 3'd3;
  localparam logic [2:0] OFS_EDGE = 3'd4;
  localparam logic [2:0] OFS_STAT = 3'd5;

  localparam int STRIDE = 8;

endpackage

// File: rtl/gpio_port_in.sv
// Input path for one GPIO port: two-flop synchroniser, optional per-bit
// debounce filter (macro GPIO_DEBOUNCE_EN), and edge detection.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   pad       : raw asynchronous pin levels
//   edge_sel  : per-bit edge polarity, 1 = falling, 0 = rising
//   in_val    : synchronised (and filtered) pin value, seen as the IN register
//   edge_hit  : one-cycle pulse per bit when the selected edge is seen
module gpio_port_in #(
  parameter int PORT_W  = 8,
  parameter int DEB_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] pad,
  input  logic [PORT_W-1:0] edge_sel,
  output logic [PORT_W-1:0] in_val,
  output logic [PORT_W-1:0] edge_hit
);

  logic [PORT_W-1:0] sync1;
  logic [PORT_W-1:0] sync2;
  logic [PORT_W-1:0] filt;
  logic [PORT_W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      prev  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [CW-1:0] cnt [PORT_W];

  // The filtered value follows sync2 only after DEB_CYC consecutive cycles
  // of disagreement; any cycle of agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      for (int b = 0; b < PORT_W; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < PORT_W; b++) begin
        if (sync2[b] == filt[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CW'(DEB_CYC - 1)) begin
          filt[b] <= sync2[b];
          cnt[b]  <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYC > 0);
  assign filt = sync2;
`endif

  assign in_val   = filt;
  assign edge_hit = (filt & ~prev & ~edge_sel) | (~filt & prev & edge_sel);

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank on the CPU data bus. NUM_PORTS ports of PORT_W
// bits, each with OUT/DIR/IN/IE/EDGE/STAT registers in an 8-byte window at
// BASE_ADDR + 8*p, plus a registered level interrupt per port.
// Optional feature macro: GPIO_DEBOUNCE_EN (per-bit input debounce).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   addr_in   : CPU address
//   mem_mode  : 00 read, 01 PC fetch, 10 write, 11 idle
//   data_in   : CPU write data
//   data_out  : combinational read data (00 unless read hit)
//   addr_hit  : address decodes to one of this bank's registers
//   pad_in    : raw pin levels
//   pad_out   : pin drive values (OUT)
//   pad_oe    : pin output enables (DIR)
//   irq       : per-port interrupt request, level, registered
// Bus semantics: there is no valid/ready handshake; mem_mode qualifies each
// cycle. A write takes effect at the posedge ending the cycle in which
// mem_mode==10 and addr_hit==1; reads are side-effect free.
module mmio_gpio_bank
  import gpio_pkg::*;
#(
  parameter int                NUM_PORTS = 2,
  parameter int                PORT_W    = 8,
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'hFFE0,
  parameter int                DEB_CYC   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr_in,
  input  logic [1:0]                  mem_mode,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out,
  output logic                        addr_hit,
  input  logic [NUM_PORTS*PORT_W-1:0] pad_in,
  output logic [NUM_PORTS*PORT_W-1:0] pad_out,
  output logic [NUM_PORTS*PORT_W-1:0] pad_oe,
  output logic [NUM_PORTS-1:0]        irq
);

  localparam logic [ADDR_W-1:0] WIN = ADDR_W'(STRIDE * NUM_PORTS);

  logic [PORT_W-1:0] out_r  [NUM_PORTS];
  logic [PORT_W-1:0] dir_r  [NUM_PORTS];
  logic [PORT_W-1:0] ie_r   [NUM_PORTS];
  logic [PORT_W-1:0] edge_r [NUM_PORTS];
  logic [PORT_W-1:0] stat_r [NUM_PORTS];
  logic [PORT_W-1:0] in_val [NUM_PORTS];
  logic [PORT_W-1:0] edge_hit [NUM_PORTS];
  logic [PORT_W-1:0] clr_mask [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_port;

  logic [ADDR_W-1:0] ofs_addr;
  logic [2:0]        reg_ofs;
  logic [1:0]        port_sel;
  logic              hit;
  logic              rd_en;
  logic              wr_en;
  logic [PORT_W-1:0] wd;
  logic [PORT_W-1:0] rd_word;
  logic              unused_data;

  // Decode: offset within the bank; offsets 6-7 of each window are holes.
  assign ofs_addr = addr_in - BASE_ADDR;
  assign reg_ofs  = ofs_addr[2:0];
  assign port_sel = ofs_addr[4:3];
  assign hit      = (addr_in >= BASE_ADDR) && (ofs_addr < WIN) && (reg_ofs <= OFS_STAT);
  assign addr_hit = hit;
  assign wd       = data_in[PORT_W-1:0];
  assign unused_data = ^data_in;

  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    case (mem_mode)
      MODE_RD:              rd_en = 1'b1;
      MODE_WRT:             wr_en = 1'b1;
      MODE_PC, MODE_IDLE:   ;
      default:              ;
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_port[p]  = wr_en && hit && (port_sel == 2'(p));
      clr_mask[p] = (wr_port[p] && (reg_ofs == OFS_STAT)) ? wd : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_r[p]  <= '0;
        dir_r[p]  <= '0;
        ie_r[p]   <= '0;
        edge_r[p] <= '0;
        stat_r[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        irq[p] <= |(stat_r[p] & ie_r[p]);
        if (wr_port[p]) begin
          case (reg_ofs)
            OFS_OUT:  out_r[p]  <= wd;
            OFS_DIR:  dir_r[p]  <= wd;
            OFS_IE:   ie_r[p]   <= wd;
            OFS_EDGE: edge_r[p] <= wd;
            default:  ;
          endcase
        end
        // New edge is OR'd after the W1C mask so a simultaneous set wins.
        stat_r[p] <= (stat_r[p] & ~clr_mask[p]) | edge_hit[p];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_sel == 2'(p)) begin
        case (reg_ofs)
          OFS_OUT:  rd_word = out_r[p];
          OFS_DIR:  rd_word = dir_r[p];
          OFS_IN:   rd_word = in_val[p];
          OFS_IE:   rd_word = ie_r[p];
          OFS_EDGE: rd_word = edge_r[p];
          OFS_STAT: rd_word = stat_r[p];
          default:  rd_word = '0;
        endcase
      end
    end
  end

  assign data_out = (rd_en && hit) ? 8'(rd_word) : 8'h00;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign pad_out[p*PORT_W +: PORT_W] = out_r[p];
    assign pad_oe[p*PORT_W +: PORT_W]  = dir_r[p];

    gpio_port_in #(
      .PORT_W  (PORT_W),
      .DEB_CYC (DEB_CYC)
    ) u_in (
      .clk      (clk),
      .rst      (rst),
      .pad      (pad_in[p*PORT_W +: PORT_W]),
      .edge_sel (edge_r[p]),
      .in_val   (in_val[p]),
      .edge_hit (edge_hit[p])
    );
  end

endmodule
